template_capture: RTL and testbench



---
 rtl/template_capture.sv | 113 +++++++++++
 tb/tb_template_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/template_capture.sv
// template_capture: grabs one frame of box-window pixels into a 2^(TX_W+TY_W) template RAM with a registered read port.
// Optional feature macro TEMPLATE_CAPTURE_CHECKSUM_EN adds a running checksum of written pixels.
`timescale 1ns/1ps
module template_capture #(
  parameter int PIX_W = 8,
  parameter int TX_W  = 6,
  parameter int TY_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture_req,
  input  logic                   abort,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [PIX_W-1:0]       pixel_data,
  input  logic                   capture_in_box,
  input  logic [TX_W-1:0]        template_x,
  input  logic [TY_W-1:0]        template_y,
  input  logic [TX_W+TY_W-1:0]   rd_addr,
  output logic [PIX_W-1:0]       rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   template_valid,
  output logic [TX_W+TY_W:0]     pixel_count
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
  ,
  output logic [PIX_W+TX_W+TY_W-1:0] checksum
`endif
);

  localparam int AW    = TX_W + TY_W;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t           state;
  logic [PIX_W-1:0] ram [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  // A pixel sharing a cycle with frame_start belongs to the next frame; abort also blocks it.
  always_comb begin
    wr_en   = (state == CAPTURE) && pixel_valid && capture_in_box && !frame_start && !abort;
    wr_addr = {template_y, template_x};
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= pixel_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      template_valid <= 1'b0;
      pixel_count    <= '0;
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture_req && !abort) begin
            state          <= ARMED;
            busy           <= 1'b1;
            pixel_count    <= '0;
            template_valid <= 1'b0;
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
            checksum       <= '0;
`endif
          end
        end
        ARMED: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (frame_start) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (frame_start) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b1;
            template_valid <= 1'b1;
          end else if (wr_en) begin
            if (pixel_count != '1) pixel_count <= pixel_count + CW'(1);
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
            checksum <= checksum + {{AW{1'b0}}, pixel_data};
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_template_capture.sv
// Scoreboard bench for template_capture: a behavioural frame-capture model feeds read/done queues drained by a monitor.
`timescale 1ns/1ps
module tb_template_capture;
  localparam int PIX_W = 8;
  localparam int TX_W  = 6;
  localparam int TY_W  = 6;
  localparam int AW    = TX_W + TY_W;
  localparam int SW    = PIX_W + AW;
  localparam int CMAX  = (1 << (AW + 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n, capture_req, abort, frame_start, pixel_valid, capture_in_box;
  logic [PIX_W-1:0] pixel_data;
  logic [TX_W-1:0]  template_x;
  logic [TY_W-1:0]  template_y;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             busy, done, template_valid;
  logic [AW:0]      pixel_count;
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
  logic [SW-1:0]    checksum;
`endif

  template_capture #(.PIX_W(PIX_W), .TX_W(TX_W), .TY_W(TY_W)) dut (
    .clk(clk), .rst_n(rst_n), .capture_req(capture_req), .abort(abort),
    .frame_start(frame_start), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .capture_in_box(capture_in_box), .template_x(template_x), .template_y(template_y),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .template_valid(template_valid), .pixel_count(pixel_count)
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: capture phase (0 idle, 1 waiting for frame, 2 grabbing) and known RAM contents.
  int   m_phase = 0;
  bit   m_tv = 0;
  int   m_cnt = 0;
  int   m_cs = 0;
  logic [PIX_W-1:0] mem [int];

  typedef struct { bit chk; logic [PIX_W-1:0] exp; int addr; } rd_item_t;
  typedef struct { int cnt; int cs; } done_item_t;
  rd_item_t   rd_q[$];
  done_item_t done_q[$];
  bit rd_req = 0;
  bit rd_req_d = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    rd_item_t it;
    int wa;
    if (rd_req) begin
      it.addr = int'(rd_addr);
      if (!rst_n) begin
        it.chk = 1; it.exp = '0;
      end else if (mem.exists(it.addr)) begin
        it.chk = 1; it.exp = mem[it.addr];
      end else begin
        it.chk = 0; it.exp = '0;
      end
      rd_q.push_back(it);
    end
    if (!rst_n) begin
      m_phase = 0; m_tv = 0; m_cnt = 0; m_cs = 0;
    end else begin
      case (m_phase)
        0: if (capture_req && !abort) begin
             m_phase = 1; m_cnt = 0; m_tv = 0; m_cs = 0;
           end
        1: if (abort) m_phase = 0;
           else if (frame_start) m_phase = 2;
        default: begin
          if (abort) m_phase = 0;
          else if (frame_start) begin
            m_phase = 0; m_tv = 1;
            done_q.push_back('{cnt: m_cnt, cs: m_cs});
          end else if (pixel_valid && capture_in_box) begin
            wa = int'(template_y) * (1 << TX_W) + int'(template_x);
            mem[wa] = pixel_data;
            if (m_cnt < CMAX) m_cnt++;
            m_cs = (m_cs + int'(pixel_data)) % (1 << SW);
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name);
    check({name, "_busy"}, busy, (m_phase != 0) ? 1 : 0);
    check({name, "_tvalid"}, template_valid, m_tv);
    check({name, "_count"}, pixel_count, m_cnt);
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
    check({name, "_checksum"}, checksum, m_cs);
`endif
  endtask

  task automatic req();
    capture_req = 1; step(); capture_req = 0;
  endtask

  task automatic fs();
    frame_start = 1; step(); frame_start = 0;
  endtask

  task automatic pix(input bit v, input bit ib, input int x, input int y, input int d);
    pixel_valid = v; capture_in_box = ib;
    template_x = TX_W'(x); template_y = TY_W'(y); pixel_data = PIX_W'(d);
    step();
    pixel_valid = 0; capture_in_box = 0;
  endtask

  task automatic rd(input int a);
    rd_addr = AW'(a); rd_req = 1; step(); rd_req = 0;
  endtask

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    rd_item_t   ri;
    done_item_t di;
    if (rd_req_d) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_queue: got read response, expected none queued");
      end else begin
        ri = rd_q.pop_front();
        if (ri.chk) check("rd_data", rd_data, ri.exp);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        di = done_q.pop_front();
        check("done_count", pixel_count, di.cnt);
        check("done_tvalid", template_valid, 1);
        check("done_busy", busy, 0);
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
        check("done_checksum", checksum, di.cs);
`endif
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; capture_req = 0; abort = 0; frame_start = 0; pixel_valid = 0;
    capture_in_box = 0; pixel_data = '0; template_x = '0; template_y = '0; rd_addr = '0;

    // Reset: reads while held in reset return 0, status cleared.
    for (int i = 0; i < 4; i++) rd(i);
    check_status("reset");
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    rst_n = 1; step();

    // Full 40x40 window capture, data = x + y.
    req(); fs();
    for (int y = 0; y < 40; y++)
      for (int x = 0; x < 40; x++) pix(1, 1, x, y, x + y);
    fs();
    check("s2_done_pulse", done, 1);
    check("s2_count", pixel_count, 1600);
    check("s2_tvalid", template_valid, 1);
`ifdef TEMPLATE_CAPTURE_CHECKSUM_EN
    check("s2_checksum", checksum, 62400);
`endif
    step();
    check("s2_done_one_cycle", done, 0);
    rd(5 * 64 + 7);
    check("s2_rd_5_7", rd_data, 12);
    for (int i = 0; i < 10; i++) rd(int'($urandom_range(39)) * 64 + int'($urandom_range(39)));

    // Invalid / out-of-box pixels do not write.
    req(); fs();
    pix(1, 0, 3, 3, 8'hEE);
    pix(0, 1, 3, 3, 8'hEE);
    check("s3_no_write_count", pixel_count, 0);
    rd(3 * 64 + 3);
    check("s3_old_value", rd_data, 6);
    for (int i = 0; i < 200; i++)
      pix(1'($urandom), 1'($urandom), int'($urandom_range(39)), int'($urandom_range(39)), int'($urandom));
    fs();
    check_status("s3");
    for (int i = 0; i < 20; i++) rd(int'($urandom_range(39)) * 64 + int'($urandom_range(39)));

    // Pixels while armed ignored; capture_req during capture ignored; closing-frame pixel dropped.
    req();
    for (int i = 0; i < 5; i++) pix(1, 1, i, i, 8'hFF);
    check("s4_armed_count", pixel_count, 0);
    fs();
    for (int i = 0; i < 10; i++) pix(1, 1, 10 + i, 20, int'($urandom));
    req();
    check("s4_req_busy", busy, 1);
    pix(1, 1, 30, 30, 8'h11);
    frame_start = 1; pixel_valid = 1; capture_in_box = 1;
    template_x = '0; template_y = '0; pixel_data = 8'h55;
    step();
    frame_start = 0; pixel_valid = 0; capture_in_box = 0;
    check("s4_count", pixel_count, 11);
    for (int i = 0; i < 5; i++) rd(i * 64 + i);
    step(); step();

    // Abort after 100 writes; abort beats frame_start; abort beats capture_req in idle.
    req(); fs();
    for (int i = 0; i < 100; i++) pix(1, 1, int'($urandom_range(39)), int'($urandom_range(39)), int'($urandom));
    abort = 1; step(); abort = 0;
    check("s5_abort_busy", busy, 0);
    check("s5_abort_tvalid", template_valid, 0);
    check("s5_abort_count", pixel_count, 100);
    step();
    req(); fs();
    for (int i = 0; i < 7; i++) pix(1, 1, i, 0, i);
    abort = 1; frame_start = 1; step(); abort = 0; frame_start = 0;
    check("s5_abort_fs_busy", busy, 0);
    check("s5_abort_fs_tvalid", template_valid, 0);
    step(); step();
    abort = 1; capture_req = 1; step(); abort = 0; capture_req = 0;
    check("s5_idle_abort_req_busy", busy, 0);

    // Reset mid-capture.
    req(); fs();
    for (int i = 0; i < 20; i++) pix(1, 1, i, 1, int'($urandom));
    rst_n = 0; step();
    check_status("s6_reset");
    check("s6_reset_done", done, 0);
    check("s6_reset_rd_data", rd_data, 0);
    rst_n = 1; step();

    // Count saturation.
    req(); fs();
    for (int i = 0; i < CMAX + 10; i++) pix(1, 1, int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom));
    check("sat_count", pixel_count, CMAX);
    fs();
    step();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      capture_req    = ($urandom_range(49) == 0);
      frame_start    = ($urandom_range(99) == 0);
      abort          = ($urandom_range(299) == 0);
      pixel_valid    = 1'($urandom);
      capture_in_box = 1'($urandom);
      template_x     = TX_W'($urandom);
      template_y     = TY_W'($urandom);
      pixel_data     = PIX_W'($urandom);
      rd_addr        = AW'($urandom);
      rd_req         = 1'($urandom);
      step();
      check_status("rand");
    end
    capture_req = 0; frame_start = 0; abort = 0; pixel_valid = 0; rd_req = 0;
    step(); step(); step();
    check("drain_done_q", done_q.size(), 0);
    check("drain_rd_q", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
